// File: rtl/res_add_wdma.sv
// Residual-add write DMA: buffers the summed pixel stream and writes it to MCIF as
// W -> H -> CH/Tout ordered bursts, pulsing done once every burst is acknowledged.
`timescale 1ns/1ps
module res_add_wdma #(
  parameter int unsigned LOG2_W   = 12,
  parameter int unsigned LOG2_H   = 12,
  parameter int unsigned LOG2_CHT = 8,
  parameter int unsigned LOG2_BL  = 4,
  parameter int unsigned DAT_W    = 256,
  parameter int unsigned OST_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LOG2_W-1:0]     w_i,
  input  logic [LOG2_H-1:0]     h_i,
  input  logic [LOG2_CHT-1:0]   ch_div_tout_i,
  input  logic [31:0]           dat_base_addr_i,
  input  logic [31:0]           surface_stride_out_i,
  input  logic [15:0]           line_stride_out_i,
  output logic                  done_o,
  input  logic                  dat_in_vld_i,
  output logic                  dat_in_rdy_o,
  input  logic [DAT_W-1:0]      dat_in_pd_i,
  output logic                  wr_req_vld_o,
  input  logic                  wr_req_rdy_i,
  output logic [LOG2_BL+63:0]   wr_req_pd_o,
  output logic                  wr_dat_vld_o,
  input  logic                  wr_dat_rdy_i,
  output logic [DAT_W-1:0]      wr_dat_pd_o,
  input  logic                  wr_rsp_vld_i
);

  localparam int unsigned Bl       = 1 << LOG2_BL;
  localparam int unsigned PixBytes = DAT_W / 8;
  localparam int unsigned Depth    = 2 * Bl;
  localparam int unsigned PtrW     = LOG2_BL + 1;
  localparam int unsigned CntW     = LOG2_BL + 2;
  localparam int unsigned BeatW    = LOG2_BL + 1;
  localparam int unsigned WbW      = LOG2_W - LOG2_BL;
  localparam logic [31:0] WStep    = 32'(Bl * PixBytes);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDrain} state_e;

  state_e              state_q;
  logic [WbW-1:0]      wb_q;
  logic [LOG2_H-1:0]   h_q;
  logic [LOG2_CHT-1:0] ch_q;
  logic [31:0]         w_bias_q, h_bias_q, ch_bias_q;
  logic [BeatW-1:0]    beat_q;
  logic                last_q;
  logic [OST_W-1:0]    ost_q, ost_d;

  logic [DAT_W-1:0]    mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     fifo_cnt_q, fifo_cnt_d;

  logic [LOG2_W-1:0]   w_m1;
  logic [WbW-1:0]      w_max;
  logic                w_last, h_last, ch_last;
  logic [LOG2_BL-1:0]  cmd_len;
  logic [BeatW-1:0]    cur_beats;
  logic [31:0]         cmd_addr;
  logic                push, pop, cmd_hs;

  // Burst geometry of the command currently pointed at by the counters.
  assign w_m1      = w_i - LOG2_W'(1);
  assign w_max     = w_m1[LOG2_W-1:LOG2_BL];
  assign w_last    = (wb_q == w_max);
  assign h_last    = (h_q == (h_i - LOG2_H'(1)));
  assign ch_last   = (ch_q == (ch_div_tout_i - LOG2_CHT'(1)));
  assign cmd_len   = w_last ? w_m1[LOG2_BL-1:0] : '1;
  assign cur_beats = BeatW'(cmd_len) + BeatW'(1);
  assign cmd_addr  = ch_bias_q + h_bias_q + w_bias_q;

  // Outputs are decodes of registered state only; done must fire in the first DRAIN cycle.
  assign dat_in_rdy_o = (fifo_cnt_q != CntW'(Depth));
  assign wr_req_vld_o = (state_q == StCmd) && (fifo_cnt_q >= CntW'(cur_beats)) && !(&ost_q);
  assign wr_req_pd_o  = {cmd_len, dat_base_addr_i, cmd_addr};
  assign wr_dat_vld_o = (state_q == StData);
  assign wr_dat_pd_o  = mem_q[rd_ptr_q];
  assign done_o       = (state_q == StDrain) && (ost_q == '0);

  assign push   = dat_in_vld_i && dat_in_rdy_o;
  assign pop    = wr_dat_vld_o && wr_dat_rdy_i;
  assign cmd_hs = wr_req_vld_o && wr_req_rdy_i;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CntW'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CntW'(1);
    end
  end

  // A response with nothing outstanding is ignored so the count never underflows.
  always_comb begin
    ost_d = ost_q;
    if (cmd_hs && !wr_rsp_vld_i) begin
      ost_d = ost_q + OST_W'(1);
    end else if (!cmd_hs && wr_rsp_vld_i && (ost_q != '0)) begin
      ost_d = ost_q - OST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dat_in_pd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ost_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fifo_cnt_q <= fifo_cnt_d;
      ost_q      <= ost_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wb_q      <= '0;
      h_q       <= '0;
      ch_q      <= '0;
      w_bias_q  <= '0;
      h_bias_q  <= '0;
      ch_bias_q <= '0;
      beat_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            wb_q      <= '0;
            h_q       <= '0;
            ch_q      <= '0;
            w_bias_q  <= '0;
            h_bias_q  <= '0;
            ch_bias_q <= '0;
            state_q   <= StCmd;
          end
        end
        StCmd: begin
          if (cmd_hs) begin
            beat_q  <= cur_beats;
            last_q  <= w_last && h_last && ch_last;
            state_q <= StData;
            // w_burst innermost, then h, then ch; each bias clears when its counter wraps.
            if (!w_last) begin
              wb_q     <= wb_q + WbW'(1);
              w_bias_q <= w_bias_q + WStep;
            end else begin
              wb_q     <= '0;
              w_bias_q <= '0;
              if (!h_last) begin
                h_q      <= h_q + LOG2_H'(1);
                h_bias_q <= h_bias_q + {16'h0000, line_stride_out_i};
              end else begin
                h_q      <= '0;
                h_bias_q <= '0;
                if (!ch_last) begin
                  ch_q      <= ch_q + LOG2_CHT'(1);
                  ch_bias_q <= ch_bias_q + surface_stride_out_i;
                end else begin
                  ch_q      <= '0;
                  ch_bias_q <= '0;
                end
              end
            end
          end
        end
        StData: begin
          if (pop) begin
            beat_q <= beat_q - BeatW'(1);
            if (beat_q == BeatW'(1)) begin
              state_q <= last_q ? StDrain : StCmd;
            end
          end
        end
        StDrain: begin
          if (ost_q == '0) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_res_add_wdma.sv
// Randomized bench for res_add_wdma: a transaction-level model derives the expected command
// list from nested W/H/CH loops and the expected write data from a queue of accepted pixels.
`timescale 1ns/1ps
module tb_res_add_wdma;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [11:0]  w;
  logic [11:0]  h;
  logic [7:0]   cht;
  logic [31:0]  base, ss;
  logic [15:0]  ls;
  logic         done;
  logic         dat_in_vld, dat_in_rdy;
  logic [255:0] dat_in_pd;
  logic         wr_req_vld, wr_req_rdy;
  logic [67:0]  wr_req_pd;
  logic         wr_dat_vld, wr_dat_rdy;
  logic [255:0] wr_dat_pd;
  logic         wr_rsp_vld;

  always #5 clk = ~clk;

  res_add_wdma dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start_i              (start),
    .w_i                  (w),
    .h_i                  (h),
    .ch_div_tout_i        (cht),
    .dat_base_addr_i      (base),
    .surface_stride_out_i (ss),
    .line_stride_out_i    (ls),
    .done_o               (done),
    .dat_in_vld_i         (dat_in_vld),
    .dat_in_rdy_o         (dat_in_rdy),
    .dat_in_pd_i          (dat_in_pd),
    .wr_req_vld_o         (wr_req_vld),
    .wr_req_rdy_i         (wr_req_rdy),
    .wr_req_pd_o          (wr_req_pd),
    .wr_dat_vld_o         (wr_dat_vld),
    .wr_dat_rdy_i         (wr_dat_rdy),
    .wr_dat_pd_o          (wr_dat_pd),
    .wr_rsp_vld_i         (wr_rsp_vld)
  );

  typedef struct {
    int          beats;
    logic [31:0] addr;
  } cmd_t;

  typedef enum int {PIdle, PCmd, PData, PDrain} phase_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start      = 1'b0;
    dat_in_vld = 1'b0;
    dat_in_pd  = '0;
    wr_req_rdy = 1'b0;
    wr_dat_rdy = 1'b0;
    wr_rsp_vld = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_req_vld"}, wr_req_vld, 1'b0);
    check({tag, "_dat_vld"}, wr_dat_vld, 1'b0);
    check({tag, "_in_rdy"}, dat_in_rdy, 1'b1);
  endtask

  // in_mode: 0 random 75%, 1 one pixel per 3 cycles, 2 every cycle.
  // rsp_mode: 0 short random latency per burst, 1 hold every response until after the last beat.
  task automatic run_case(input int wv, input int hv, input int cv, input logic [31:0] basev,
                          input logic [31:0] ssv, input logic [15:0] lsv, input int start_cyc,
                          input int in_mode, input int rdy_pct, input int rsp_mode,
                          input int abort_beats);
    cmd_t         exp_cmds[$];
    cmd_t         e;
    logic [255:0] dq[$];
    int           rsp_q[$];
    logic [255:0] p;
    phase_t       phase;
    int total, sent, cyc, stop_at, beats_hs, cmd_idx, beats_left, ost, done_seen;
    bit pushed, exp_req, exp_done, push, cmd_hs, dat_hs;

    for (int c = 0; c < cv; c++) begin
      for (int y = 0; y < hv; y++) begin
        for (int b = 0; b * 16 < wv; b++) begin
          e.beats = (wv - b * 16 > 16) ? 16 : wv - b * 16;
          e.addr  = 32'(c) * ssv + 32'(y) * {16'h0000, lsv} + 32'(b * 512);
          exp_cmds.push_back(e);
        end
      end
    end

    w = 12'(wv); h = 12'(hv); cht = 8'(cv); base = basev; ss = ssv; ls = lsv;
    total = wv * hv * cv;
    sent = 0; cyc = 0; stop_at = -1; beats_hs = 0; cmd_idx = 0; beats_left = 0;
    ost = 0; done_seen = 0; pushed = 1'b0; phase = PIdle;

    while (cyc < 8000 && (stop_at < 0 || cyc < stop_at)) begin
      @(posedge clk); #1;
      start = (cyc == start_cyc);
      if (!dat_in_vld || pushed) begin
        dat_in_vld = 1'b0;
        if (sent < total && ((in_mode == 0 && $urandom_range(99) < 75) ||
                             (in_mode == 1 && cyc % 3 == 0) || in_mode == 2)) begin
          for (int i = 0; i < 8; i++) p[i*32 +: 32] = $urandom;
          dat_in_vld = 1'b1;
          dat_in_pd  = p;
        end
      end
      wr_req_rdy = ($urandom_range(99) < rdy_pct);
      wr_dat_rdy = ($urandom_range(99) < rdy_pct);
      wr_rsp_vld = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0] <= cyc) begin
        wr_rsp_vld = 1'b1;
        void'(rsp_q.pop_front());
      end

      @(negedge clk);
      exp_req  = (phase == PCmd) && (dq.size() >= exp_cmds[cmd_idx].beats);
      exp_done = (phase == PDrain) && (ost == 0);
      check("in_rdy", dat_in_rdy, dq.size() != 32);
      check("req_vld", wr_req_vld, exp_req);
      if (exp_req) begin
        check("cmd_pd", wr_req_pd, {4'(exp_cmds[cmd_idx].beats - 1), basev,
                                    exp_cmds[cmd_idx].addr});
      end
      check("dat_vld", wr_dat_vld, phase == PData);
      if (phase == PData) check("dat_pd", wr_dat_pd, dq[0]);
      check("done", done, exp_done);
      if (done) done_seen++;

      push   = dat_in_vld && (dq.size() != 32);
      cmd_hs = exp_req && wr_req_rdy;
      dat_hs = (phase == PData) && wr_dat_rdy;
      pushed = push;
      if (push) begin
        dq.push_back(dat_in_pd);
        sent++;
      end
      if (dat_hs) void'(dq.pop_front());
      if (wr_rsp_vld && ost > 0) ost--;
      if (cmd_hs) begin
        ost++;
        beats_left = exp_cmds[cmd_idx].beats;
        cmd_idx++;
        phase = PData;
      end else if (dat_hs) begin
        beats_hs++;
        beats_left--;
        if (beats_left == 0) begin
          rsp_q.push_back((rsp_mode == 1) ? 32'h4000_0000 : cyc + 1 + $urandom_range(3));
          if (cmd_idx == exp_cmds.size()) begin
            phase = PDrain;
            if (rsp_mode == 1) foreach (rsp_q[i]) rsp_q[i] = cyc + 5;
          end else begin
            phase = PCmd;
          end
        end
      end else if (exp_done) begin
        phase   = PIdle;
        stop_at = cyc + 4;
      end else if (phase == PIdle && start) begin
        phase = PCmd;
      end

      if (abort_beats > 0 && beats_hs == abort_beats) begin
        check("abort_in_data", wr_dat_vld, 1'b1);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        return;
      end
      cyc++;
    end
    check("timeout", phase == PIdle && stop_at >= 0, 1'b1);
    check("done_pulses", done_seen, 1);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    w = 12'd1; h = 12'd1; cht = 8'd1; base = '0; ss = '0; ls = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);

    run_case(16, 1, 1, 32'h8000, 32'h0, 16'h0, 20, 0, 100, 0, 0);
    run_case(20, 2, 2, 32'h0, 32'h1000, 16'h400, 5, 2, 100, 0, 0);
    run_case(40, 1, 1, 32'h100, 32'h0, 16'h0, 0, 1, 100, 0, 0);
    run_case(37, 3, 2, $urandom, $urandom, 16'($urandom), 60, 0, 50, 0, 0);
    run_case(50, 2, 1, 32'hFFFF_FF00, 32'h0, 16'h800, 10, 2, 80, 1, 0);
    run_case(1, 3, 2, 32'h40, 32'h2000, 16'h100, 3, 0, 70, 0, 0);
    run_case(20, 2, 2, 32'h0, 32'h1000, 16'h400, 5, 2, 100, 0, 22);
    run_case(20, 2, 2, 32'h0, 32'h1000, 16'h400, 5, 2, 100, 0, 0);
    for (int k = 0; k < 3; k++) begin
      run_case($urandom_range(70, 1), $urandom_range(3, 1), $urandom_range(3, 1), $urandom,
               $urandom, 16'($urandom), $urandom_range(40), 0, 60, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
